// File: rtl/fetch_pc_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit_pkg
//
// Purpose: definitions shared by the fetch-side PC unit and any block that
// needs to interpret its state: FSM state encodings, the default reset PC,
// the kill-counter ceiling and a small address-alignment helper.
//
// Contents:
//   fetch_state_e  - 2-bit FSM state encoding (IDLE/FETCH/WAIT/DRAIN)
//   PC_RESET       - default program counter after reset
//   KILL_MAX       - saturation value of the discarded-response counter
//   PC_STEP        - byte increment between sequential fetches
//   align_word()   - forces a byte address onto a 4-byte boundary
// -----------------------------------------------------------------------------
package fetch_pc_unit_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,  // one cycle after reset before fetching starts
        FETCH_FETCH = 2'd1,  // free to issue a request
        FETCH_WAIT  = 2'd2,  // one request outstanding, response wanted
        FETCH_DRAIN = 2'd3   // one request outstanding, response unwanted
    } fetch_state_e;

    localparam logic [31:0] PC_RESET = 32'h0000_2000;
    localparam logic [7:0]  KILL_MAX = 8'hFF;
    localparam logic [31:0] PC_STEP  = 32'd4;

    // Instructions are word aligned; the low two address bits are dropped.
    // Masking (rather than slicing) keeps every bit of the argument in use.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit
//
// Purpose: fetch stage program-counter unit. Holds the PC, issues one
// instruction-memory request at a time, places each returned instruction
// into a single output slot for decode, and honours single-cycle redirects
// from execute. A redirect while a request is outstanding causes the
// eventual response to be thrown away (and counted).
//
// Parameters:
//   RESET_PC         - PC loaded on reset
//
// Ports:
//   clk              in   system clock, all state on the rising edge
//   reset            in   asynchronous active-high reset
//   stall            in   decode cannot accept; output slot is held
//   pcsel            in   redirect from execute (taken branch/jump)
//   alu_target[31:0] in   redirect target (low two bits ignored)
//   imem_req_valid   out  request valid (combinational on stall/pcsel)
//   imem_req_ready   in   memory accepts the request
//   imem_addr[31:0]  out  request address, always the current PC
//   imem_resp_valid  in   response valid, one per accepted request
//   imem_resp_data   in   returned instruction word
//   inst_valid       out  output slot holds an instruction
//   inst[31:0]       out  instruction in the slot
//   inst_pc[31:0]    out  PC of that instruction
//   kill_count[7:0]  out  saturating count of discarded responses
// -----------------------------------------------------------------------------
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = PC_RESET
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        pcsel,
    input  logic [31:0] alu_target,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [7:0]  kill_count
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    fetch_state_e state_q, state_d;

    logic [31:0] pc_q,         pc_d;
    logic [31:0] req_pc_q,     req_pc_d;      // PC of the outstanding request
    logic        inst_valid_q, inst_valid_d;
    logic [31:0] inst_q,       inst_d;
    logic [31:0] inst_pc_q,    inst_pc_d;
    logic [7:0]  kill_count_q, kill_count_d;

    // -------------------------------------------------------------------------
    // Slot occupancy helpers
    // -------------------------------------------------------------------------
    logic consume;     // decode takes the slot contents this cycle
    logic slot_free;   // slot will have room by the next edge

    assign consume   = inst_valid_q & ~stall;
    assign slot_free = ~inst_valid_q | consume;

    // -------------------------------------------------------------------------
    // FSM output decode
    // -------------------------------------------------------------------------
    logic req_valid;     // request offered to memory
    logic handshake;     // request accepted this cycle
    logic resp_accept;   // response goes into the slot
    logic resp_kill;     // response is thrown away

    always_comb begin
        req_valid   = 1'b0;
        resp_accept = 1'b0;
        resp_kill   = 1'b0;
        case (state_q)
            FETCH_FETCH: begin
                // Only ask for a new word when the slot can take it, and never
                // while being redirected: the PC is about to change.
                req_valid = slot_free & ~pcsel;
            end
            FETCH_WAIT: begin
                resp_accept = imem_resp_valid & ~pcsel;
                resp_kill   = imem_resp_valid &  pcsel;
            end
            FETCH_DRAIN: begin
                resp_kill = imem_resp_valid;
            end
            default: begin
                // IDLE: nothing is outstanding; stray responses are ignored.
            end
        endcase
    end

    assign handshake = req_valid & imem_req_ready;

    // -------------------------------------------------------------------------
    // FSM next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH_IDLE: begin
                state_d = FETCH_FETCH;
            end
            FETCH_FETCH: begin
                // handshake is already suppressed by pcsel, so a redirect
                // here simply keeps us in FETCH.
                if (handshake) begin
                    state_d = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (imem_resp_valid) begin
                    // Either kept or killed, the request is finished.
                    state_d = FETCH_FETCH;
                end else if (pcsel) begin
                    state_d = FETCH_DRAIN;
                end
            end
            FETCH_DRAIN: begin
                if (imem_resp_valid) begin
                    state_d = FETCH_FETCH;
                end
            end
            default: begin
                state_d = FETCH_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath next-state logic
    // -------------------------------------------------------------------------

    // Program counter: a redirect overrides sequential advance.
    always_comb begin
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        if (pcsel) begin
            pc_d = align_word(alu_target);
        end else if (handshake) begin
            pc_d = pc_q + PC_STEP;   // wraps naturally at 2^32
        end
        if (handshake) begin
            req_pc_d = pc_q;
        end
    end

    // Output slot: a redirect empties it even while decode is stalled, since
    // whatever it holds is on the wrong path.
    always_comb begin
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        if (pcsel) begin
            inst_valid_d = 1'b0;
        end else if (resp_accept) begin
            inst_valid_d = 1'b1;
            inst_d       = imem_resp_data;
            inst_pc_d    = req_pc_q;
        end else if (consume) begin
            inst_valid_d = 1'b0;
        end
    end

    // Discarded-response counter, saturating.
    always_comb begin
        kill_count_d = kill_count_q;
        if (resp_kill && (kill_count_q != KILL_MAX)) begin
            kill_count_d = kill_count_q + 8'd1;
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= FETCH_IDLE;
            pc_q         <= RESET_PC;
            req_pc_q     <= '0;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            kill_count_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            kill_count_q <= kill_count_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign imem_req_valid = req_valid;
    assign imem_addr      = pc_q;
    assign inst_valid     = inst_valid_q;
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;
    assign kill_count     = kill_count_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_pc_unit
//
// Directed bench for fetch_pc_unit. A small memory model answers each
// accepted request after mem_lat cycles with word_of(addr). Inputs are driven
// just after the rising edge, outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_fetch_pc_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        pcsel;
    logic [31:0] alu_target;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [7:0]  kill_count;

    int n_checks;
    int n_fail;

    // memory model state
    int          mem_lat;
    logic        pend;
    int          pend_cnt;
    logic [31:0] pend_addr;

    fetch_pc_unit dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .pcsel           (pcsel),
        .alu_target      (alu_target),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .kill_count      (kill_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // Memory: sees the handshake on the falling edge before the accepting
    // rising edge, answers mem_lat cycles later for one cycle.
    always @(negedge clk) begin
        if (reset) begin
            pend            = 1'b0;
            imem_resp_valid = 1'b0;
        end else begin
            imem_resp_valid = 1'b0;
            if (pend) begin
                if (pend_cnt <= 1) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = word_of(pend_addr);
                    pend            = 1'b0;
                end else begin
                    pend_cnt = pend_cnt - 1;
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                pend      = 1'b1;
                pend_cnt  = mem_lat;
                pend_addr = imem_addr;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic at_neg;
        @(negedge clk);
    endtask

    task automatic at_drive;
        @(posedge clk);
        #1;
    endtask

    // Starts in drive phase, returns on the falling edge of the handshake.
    task automatic wait_req(input string tag, input logic [31:0] exp_addr, output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            at_neg();
            n = n + 1;
            if (imem_req_valid && imem_req_ready) begin
                check(tag, imem_addr, exp_addr);
                return;
            end
            at_drive();
        end
        check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Starts in drive phase, returns on the falling edge where the slot fills.
    task automatic wait_inst(input string tag, input logic [31:0] exp_pc);
        for (int i = 0; i < 20; i++) begin
            at_neg();
            if (inst_valid) begin
                check({tag, "_pc"}, inst_pc, exp_pc);
                check({tag, "_word"}, inst, word_of(exp_pc));
                return;
            end
            at_drive();
        end
        check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        n_checks        = 0;
        n_fail          = 0;
        mem_lat         = 1;
        pend            = 1'b0;
        pend_cnt        = 0;
        pend_addr       = '0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        reset           = 1'b1;
        stall           = 1'b0;
        pcsel           = 1'b0;
        alu_target      = '0;
        imem_req_ready  = 1'b1;

        // ---- reset values
        repeat (3) @(posedge clk);
        #1;
        at_neg();
        check("rst_req_valid",  32'(imem_req_valid), 32'd0);
        check("rst_inst_valid", 32'(inst_valid),     32'd0);
        check("rst_inst",       inst,                32'd0);
        check("rst_inst_pc",    inst_pc,             32'd0);
        check("rst_kill",       32'(kill_count),     32'd0);
        check("rst_addr",       imem_addr,           32'h0000_2000);

        // ---- sequential fetch, 1-cycle memory
        at_drive(); reset = 1'b0;
        at_neg();   check("idle_no_req", 32'(imem_req_valid), 32'd0);
        at_drive();
        at_neg();   check("req0_valid", 32'(imem_req_valid), 32'd1);
                    check("req0_addr",  imem_addr, 32'h0000_2000);
        at_drive();
        at_neg();   check("resp0_not_yet", 32'(inst_valid), 32'd0);
        at_drive();
        at_neg();   check("inst0_valid", 32'(inst_valid), 32'd1);
                    check("inst0_pc",    inst_pc, 32'h0000_2000);
                    check("inst0_word",  inst, word_of(32'h0000_2000));
                    check("req1_addr",   imem_addr, 32'h0000_2004);
        at_drive(); stall = 1'b1;
        at_neg();   check("gap1_inst_valid", 32'(inst_valid), 32'd0);

        // ---- stall with slot full holding 0x2004
        at_drive();
        at_neg();   check("inst1_valid", 32'(inst_valid), 32'd1);
                    check("inst1_pc",    inst_pc, 32'h0000_2004);
                    check("stall_no_req", 32'(imem_req_valid), 32'd0);
        for (int i = 0; i < 5; i++) begin
            at_drive();
            at_neg();
            check("stall_hold_valid", 32'(inst_valid), 32'd1);
            check("stall_hold_pc",    inst_pc, 32'h0000_2004);
            check("stall_hold_word",  inst, word_of(32'h0000_2004));
            check("stall_hold_noreq", 32'(imem_req_valid), 32'd0);
        end
        at_drive(); stall = 1'b0;
        at_neg();   check("release_req_valid", 32'(imem_req_valid), 32'd1);
                    check("release_req_addr",  imem_addr, 32'h0000_2008);
        at_drive();
        at_neg();   check("release_consumed", 32'(inst_valid), 32'd0);
        at_drive(); mem_lat = 3;
        at_neg();   check("inst2_pc", inst_pc, 32'h0000_2008);
                    check("req3_addr", imem_addr, 32'h0000_200C);

        // ---- redirect while WAIT without response -> DRAIN
        at_drive(); pcsel = 1'b1; alu_target = 32'h0000_3003;
        at_neg();   check("redir_wait_noreq", 32'(imem_req_valid), 32'd0);
                    check("redir_wait_noinst", 32'(inst_valid), 32'd0);
        at_drive(); pcsel = 1'b0;
        at_neg();   check("drain_noreq", 32'(imem_req_valid), 32'd0);
                    check("drain_kill0", 32'(kill_count), 32'd0);
        at_drive(); mem_lat = 1;
        at_neg();   check("drain_resp_noinst", 32'(inst_valid), 32'd0);
                    check("drain_resp_noreq", 32'(imem_req_valid), 32'd0);
        at_drive();
        at_neg();   check("kill_after_drain", 32'(kill_count), 32'd1);
                    check("target_req_valid", 32'(imem_req_valid), 32'd1);
                    check("target_req_addr",  imem_addr, 32'h0000_3000);
                    check("target_noinst",    32'(inst_valid), 32'd0);
        at_drive();
        wait_inst("inst_3000", 32'h0000_3000);

        // ---- redirect in the same cycle as the response
        at_drive(); pcsel = 1'b1; alu_target = 32'h0000_4000;
        at_neg();   check("same_cyc_noreq", 32'(imem_req_valid), 32'd0);
                    check("same_cyc_noinst", 32'(inst_valid), 32'd0);
        at_drive(); pcsel = 1'b0; mem_lat = 4;
        at_neg();   check("same_cyc_fetch_req", 32'(imem_req_valid), 32'd1);
                    check("same_cyc_addr",  imem_addr, 32'h0000_4000);
                    check("same_cyc_kill",  32'(kill_count), 32'd2);
                    check("same_cyc_noinst2", 32'(inst_valid), 32'd0);

        // ---- two redirects: WAIT -> DRAIN, then again in DRAIN
        at_drive(); pcsel = 1'b1; alu_target = 32'h0000_5000;
        at_neg();   check("dbl_redir1_noreq", 32'(imem_req_valid), 32'd0);
        at_drive(); alu_target = 32'h0000_6008;
        at_neg();   check("dbl_redir2_noreq", 32'(imem_req_valid), 32'd0);
        at_drive(); pcsel = 1'b0; mem_lat = 1;
        wait_req("last_target_wins", 32'h0000_6008, n);
        check("dbl_redir_kill", 32'(kill_count), 32'd3);
        at_drive();
        wait_inst("inst_6008", 32'h0000_6008);

        // ---- PC wrap at 0xFFFF_FFFC
        at_drive(); pcsel = 1'b1; alu_target = 32'hFFFF_FFFC;
        at_neg();
        at_drive(); pcsel = 1'b0;
        wait_req("wrap_src_addr", 32'hFFFF_FFFC, n);
        check("wrap_kill", 32'(kill_count), 32'd4);
        at_drive();
        wait_inst("inst_fffffffc", 32'hFFFF_FFFC);
        check("wrap_req_valid", 32'(imem_req_valid), 32'd1);
        check("wrap_req_addr",  imem_addr, 32'h0000_0000);

        // ---- 300 kills: counter saturates
        for (int i = 0; i < 300; i++) begin
            at_drive(); pcsel = 1'b1; alu_target = 32'h0000_0100;
            at_neg();
            at_drive(); pcsel = 1'b0;
            wait_req("kill_loop_addr", 32'h0000_0100, n);
        end
        check("kill_saturated", 32'(kill_count), 32'd255);

        // ---- asynchronous reset with the slot holding an instruction
        at_drive(); stall = 1'b1;
        wait_inst("inst_0100", 32'h0000_0100);
        at_drive(); reset = 1'b1;
        #1;
        check("async_rst_inst_valid", 32'(inst_valid),     32'd0);
        check("async_rst_inst",       inst,                32'd0);
        check("async_rst_inst_pc",    inst_pc,             32'd0);
        check("async_rst_kill",       32'(kill_count),     32'd0);
        check("async_rst_req_valid",  32'(imem_req_valid), 32'd0);
        check("async_rst_addr",       imem_addr,           32'h0000_2000);
        stall = 1'b0;
        at_drive(); reset = 1'b0;
        wait_req("post_rst_addr", 32'h0000_2000, n);
        check("post_rst_req_cycle", 32'(n), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Fetch-side counterpart to the execute-stage control logic: holds the program counter, issues instruction-memory requests, and returns fetched instructions to decode. It consumes the execute stage's `pcsel` redirect and branch/jump target. It supports one outstanding memory request and a one-entry output slot. After a redirect it discards in-flight responses.

## Interface
- `RESET_PC`, 32'h0000_2000, PC value loaded on reset.
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `stall`  in  1  decode cannot accept; holds the output slot.
- `pcsel`  in  1  single-cycle redirect from execute (taken branch/jump).
- `alu_target`  in  32  redirect target from execute ALU.
- `imem_req_valid`  out  1  request valid.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_addr`  out  32  request address (= pc).
- `imem_resp_valid`  in  1  response valid (exactly one per accepted request, ≥1 cycle later).
- `imem_resp_data`  in  32  instruction word.
- `inst_valid`  out  1  output slot holds an instruction.
- `inst`  out  32  instruction word.
- `inst_pc`  out  32  PC of `inst`.
- `kill_count`  out  8  saturating count of discarded responses.

## Operation
- States:
  - IDLE: entered on reset; goes to FETCH next cycle.
  - FETCH: issues a request when allowed.
  - WAIT: a request is outstanding.
  - DRAIN: an outstanding request is to be discarded.
- Definitions:
  - consume = `inst_valid & ~stall`.
  - slot_free = `~inst_valid | consume`.
- Request issue:
  - `imem_req_valid` = (state==FETCH) & slot_free & ~`pcsel`. This is combinational on `pcsel` and `stall`.
  - `imem_addr` = pc.
- Handshake (`imem_req_valid & imem_req_ready`):
  - latch req_pc ← pc;
  - pc ← pc+4, wrapping modulo 2^32;
  - go to WAIT.
- WAIT with `imem_resp_valid` and no `pcsel`:
  - slot ← {`imem_resp_data`, req_pc};
  - `inst_valid` ← 1;
  - go to FETCH.
- Slot clear: on consume with no new write, `inst_valid` ← 0.
- Redirect (`pcsel`=1), which takes priority over everything else:
  - pc ← {`alu_target`[31:2], 2'b00};
  - `inst_valid` ← 0, even if `stall`.
  - In FETCH: no request this cycle; stay in FETCH.
  - In WAIT without response: go to DRAIN.
  - In WAIT with response in the same cycle: discard the response, increment `kill_count`, go to FETCH.
  - In DRAIN: update pc only; stay in DRAIN.
- DRAIN: on `imem_resp_valid`, discard the response, increment `kill_count`, go to FETCH.
- `kill_count` saturates at 255.
- Responses arriving in IDLE or FETCH are protocol errors; ignore them.

## Timing
- Reset values:
  - pc=`RESET_PC`, state=IDLE;
  - `imem_req_valid`=0, `inst_valid`=0, `inst`=0, `inst_pc`=0, `kill_count`=0.
- First request is asserted in the 2nd cycle after reset deassertion (IDLE, then FETCH).
- Latency:
  - response cycle → `inst_valid` on the next edge: 1 cycle.
  - handshake → earliest `inst_valid`: 2 cycles.
- Throughput: at most one instruction per 2 cycles, since issue and response cannot overlap.
- Slot stability: `inst`/`inst_pc` are stable while `inst_valid & stall`; only `pcsel` may clear them.
- `imem_req_valid` may drop without a handshake (stall, `pcsel`); `imem_addr` may change when it re-asserts.
- Reset mid-transaction: everything returns to reset values immediately. Memory must not return a response for a pre-reset request.

## Structure
- Shared defines header holds:
  - state encodings `FETCH_IDLE`/`FETCH_FETCH`/`FETCH_WAIT`/`FETCH_DRAIN` (2 bits);
  - the default `PC_RESET` (32'h0000_2000).
- Single module. No sub-module is warranted: the FSM, pc, slot and counter are tightly coupled.

## Test plan
- Reset, then `imem_req_ready`=1 with 1-cycle memory: addresses 0x2000, 0x2004, 0x2008 in order; `inst_pc` matches each; `inst_valid` pulses every 2 cycles.
- `stall`=1 with slot full holding 0x2004: `imem_req_valid`=0, slot unchanged for 5 cycles. Release: slot consumed, next request 0x2008.
- `pcsel` with `alu_target`=0x3003 while in WAIT: response discarded, `kill_count`=1, next request 0x3000, `inst_valid` never shows the discarded word.
- `pcsel` in the same cycle as the response: that response is dropped, state goes to FETCH, next request is at the target. A second `pcsel` during DRAIN: last target wins.
- PC=0xFFFF_FFFC fetched: next request 0x0000_0000. 300 kills: `kill_count` holds 255.
- Assert `reset` while in WAIT with a slot valid: all outputs zero at once; after deassertion, the first request is 0x2000.
